// File: rtl/core_mmu_walker.sv
// Two-level ARMv4/v5 page-table walker with domain and access-permission checks.
// Produces one translation per request and captures abort status for the CP15 FSR/FAR.
module core_mmu_walker (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmu_enable,
  input  logic [31:0] ttbr,
  input  logic [31:0] dacr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_va,
  input  logic        req_priv,
  input  logic        req_write,
  output logic        bus_start,
  output logic [29:0] bus_addr,
  input  logic        bus_ready,
  input  logic [31:0] bus_data_rd,
  output logic        resp_valid,
  output logic        resp_fault,
  output logic [31:0] resp_pa,
  output logic        fault_register,
  output logic        fault_page,
  output logic [1:0]  fault_type,
  output logic [3:0]  fault_domain,
  output logic [31:0] fault_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_L1_REQ, S_L1_WAIT, S_L2_REQ, S_L2_WAIT, S_CHECK, S_RESP
  } state_e;

  localparam logic [1:0] FT_NONE   = 2'b00;
  localparam logic [1:0] FT_TRANS  = 2'b01;
  localparam logic [1:0] FT_DOMAIN = 2'b10;
  localparam logic [1:0] FT_PERM   = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] va_q, va_d;
  logic        priv_q, priv_d;
  logic        write_q, write_d;
  logic        l2_q, l2_d;
  logic [3:0]  dom_q, dom_d;
  logic [1:0]  ap_q, ap_d;
  logic [31:0] pa_q, pa_d;
  logic [1:0]  ftype_q, ftype_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic        fpage_q;
  logic [1:0]  ftype_out_q;
  logic [3:0]  fdom_q;
  logic [31:0] faddr_q;
  logic        unused_ok;

  // Domain control 11 bypasses AP; 00/10 abort; 01 (client) applies AP rules.
  function automatic logic [1:0] access_check(input logic [1:0] dom_ctl, input logic [1:0] ap,
                                              input logic priv, input logic wr);
    logic [1:0] ft;
    ft = FT_NONE;
    case (dom_ctl)
      2'b11: ft = FT_NONE;
      2'b01: begin
        case (ap)
          2'b00:   ft = FT_PERM;
          2'b01:   if (!priv) ft = FT_PERM;
          2'b10:   if (!priv && wr) ft = FT_PERM;
          default: ft = FT_NONE;
        endcase
      end
      default: ft = FT_DOMAIN;
    endcase
    return ft;
  endfunction

  always_comb begin
    state_d    = state_q;
    va_d       = va_q;
    priv_d     = priv_q;
    write_d    = write_q;
    l2_d       = l2_q;
    dom_d      = dom_q;
    ap_d       = ap_q;
    pa_d       = pa_q;
    ftype_d    = ftype_q;
    bus_addr_d = bus_addr_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          va_d    = req_va;
          priv_d  = req_priv;
          write_d = req_write;
          l2_d    = 1'b0;
          dom_d   = 4'd0;
          ap_d    = 2'b00;
          ftype_d = FT_NONE;
          pa_d    = req_va;
          if (mmu_enable) begin
            bus_addr_d = {ttbr[31:14], req_va[31:20]};
            state_d    = S_L1_REQ;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_L1_REQ: state_d = S_L1_WAIT;
      S_L1_WAIT: begin
        if (bus_ready) begin
          case (bus_data_rd[1:0])
            2'b10: begin
              dom_d   = bus_data_rd[8:5];
              ap_d    = bus_data_rd[11:10];
              pa_d    = {bus_data_rd[31:20], va_q[19:0]};
              state_d = S_CHECK;
            end
            2'b01: begin
              dom_d      = bus_data_rd[8:5];
              l2_d       = 1'b1;
              bus_addr_d = {bus_data_rd[31:10], va_q[19:12]};
              state_d    = S_L2_REQ;
            end
            default: begin
              ftype_d = FT_TRANS;
              dom_d   = 4'd0;
              l2_d    = 1'b0;
              state_d = S_RESP;
            end
          endcase
        end
      end
      S_L2_REQ: state_d = S_L2_WAIT;
      S_L2_WAIT: begin
        if (bus_ready) begin
          ap_d = bus_data_rd[5:4];
          case (bus_data_rd[1:0])
            2'b01: begin
              pa_d    = {bus_data_rd[31:16], va_q[15:0]};
              state_d = S_CHECK;
            end
            2'b10: begin
              pa_d    = {bus_data_rd[31:12], va_q[11:0]};
              state_d = S_CHECK;
            end
            default: begin
              ftype_d = FT_TRANS;
              state_d = S_RESP;
            end
          endcase
        end
      end
      S_CHECK: begin
        ftype_d = access_check(dacr[{dom_q, 1'b0} +: 2], ap_q, priv_q, write_q);
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      va_q        <= '0;
      priv_q      <= 1'b0;
      write_q     <= 1'b0;
      l2_q        <= 1'b0;
      dom_q       <= '0;
      ap_q        <= '0;
      pa_q        <= '0;
      ftype_q     <= FT_NONE;
      bus_addr_q  <= '0;
      fpage_q     <= 1'b0;
      ftype_out_q <= FT_NONE;
      fdom_q      <= '0;
      faddr_q     <= '0;
    end else begin
      state_q    <= state_d;
      va_q       <= va_d;
      priv_q     <= priv_d;
      write_q    <= write_d;
      l2_q       <= l2_d;
      dom_q      <= dom_d;
      ap_q       <= ap_d;
      pa_q       <= pa_d;
      ftype_q    <= ftype_d;
      bus_addr_q <= bus_addr_d;
      // Capture status on the edge into RESP so it is valid alongside fault_register.
      if (state_d == S_RESP && ftype_d != FT_NONE) begin
        fpage_q     <= l2_d;
        ftype_out_q <= ftype_d;
        fdom_q      <= dom_d;
        faddr_q     <= va_q;
      end
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign bus_start      = (state_q == S_L1_REQ) || (state_q == S_L2_REQ);
  assign bus_addr       = bus_addr_q;
  assign resp_valid     = (state_q == S_RESP);
  assign resp_fault     = resp_valid && (ftype_q != FT_NONE);
  assign resp_pa        = (resp_valid && !resp_fault) ? pa_q : 32'd0;
  assign fault_register = resp_fault;
  assign fault_page     = fpage_q;
  assign fault_type     = ftype_out_q;
  assign fault_domain   = fdom_q;
  assign fault_addr     = faddr_q;

  // Low TTBR bits and the C/B descriptor bits play no part in translation.
  assign unused_ok = ^{ttbr[13:0], bus_data_rd[3:2]};

endmodule

// File: tb/tb_core_mmu_walker.sv
// Directed bench for core_mmu_walker: section, page and fault walks with
// hand-computed addresses, latencies and fault status.
module tb_core_mmu_walker;
  logic        clk = 1'b0;
  logic        rst;
  logic        mmu_enable;
  logic [31:0] ttbr, dacr;
  logic        req_valid, req_ready;
  logic [31:0] req_va;
  logic        req_priv, req_write;
  logic        bus_start;
  logic [29:0] bus_addr;
  logic        bus_ready;
  logic [31:0] bus_data_rd;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_pa;
  logic        fault_register, fault_page;
  logic [1:0]  fault_type;
  logic [3:0]  fault_domain;
  logic [31:0] fault_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  core_mmu_walker dut (
    .clk(clk), .rst(rst), .mmu_enable(mmu_enable), .ttbr(ttbr), .dacr(dacr),
    .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va),
    .req_priv(req_priv), .req_write(req_write),
    .bus_start(bus_start), .bus_addr(bus_addr), .bus_ready(bus_ready),
    .bus_data_rd(bus_data_rd),
    .resp_valid(resp_valid), .resp_fault(resp_fault), .resp_pa(resp_pa),
    .fault_register(fault_register), .fault_page(fault_page),
    .fault_type(fault_type), .fault_domain(fault_domain), .fault_addr(fault_addr)
  );

  // Issues one request and acts as the descriptor memory; cycle 0 is the accept cycle.
  task automatic run_walk(input logic [31:0] va, input logic priv, input logic wr,
                          input logic mmu, input logic [31:0] l1, input logic [31:0] l2,
                          input int waits, output int lat, output logic flt,
                          output logic [31:0] pa, output logic freg,
                          output logic [29:0] a1, output logic [29:0] a2);
    int rdy_at;
    int nbus;
    lat = -1; flt = 1'b0; pa = '0; freg = 1'b0; a1 = '0; a2 = '0;
    rdy_at = -1; nbus = 0;
    req_valid = 1'b1; req_va = va; req_priv = priv; req_write = wr; mmu_enable = mmu;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus_start) begin
        nbus++;
        if (nbus == 1) a1 = bus_addr; else a2 = bus_addr;
        rdy_at = c + 1 + waits;
      end
      if (resp_valid) begin
        lat = c; flt = resp_fault; pa = resp_pa; freg = fault_register;
        break;
      end
      if (c == rdy_at) begin
        bus_ready = 1'b1; bus_data_rd = (nbus == 1) ? l1 : l2;
      end else begin
        bus_ready = 1'b0; bus_data_rd = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
    end
    bus_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", req_ready); end
    tests++;
    if ({bus_start, resp_valid, resp_fault, fault_register, fault_page, fault_type,
         fault_domain, resp_pa, fault_addr, bus_addr} !== '0) begin
      fails++; $display("FAIL reset_outputs got nonzero (pa %h faddr %h baddr %h) want 0",
                        resp_pa, fault_addr, bus_addr);
    end
  endtask

  task automatic test_mmu_off();
    int lat; logic flt, freg; logic [31:0] pa; logic [29:0] a1, a2;
    run_walk(32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, lat, flt, pa, freg, a1, a2);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL off_lat got %0d want 1", lat); end
    tests++;
    if (pa !== 32'h1234_5678) begin fails++; $display("FAIL off_pa got %h want 12345678", pa); end
    tests++;
    if (freg !== 1'b0) begin fails++; $display("FAIL off_freg got %b want 0", freg); end
  endtask

  task automatic test_section();
    int lat; logic flt, freg; logic [31:0] pa; logic [29:0] a1, a2;
    ttbr = 32'h0000_4000; dacr = 32'h1;
    run_walk(32'h0030_0ABC, 1'b0, 1'b1, 1'b1, 32'h8000_0C02, 32'h0, 0, lat, flt, pa, freg, a1, a2);
    tests++;
    if (a1 !== 30'h1003) begin fails++; $display("FAIL sec_addr got %h want 1003", a1); end
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL sec_lat got %0d want 4", lat); end
    tests++;
    if ({flt, pa} !== {1'b0, 32'h8000_0ABC}) begin
      fails++; $display("FAIL sec_pa got %b/%h want 0/80000abc", flt, pa);
    end
  endtask

  task automatic test_bus_wait();
    int lat; logic flt, freg; logic [31:0] pa; logic [29:0] a1, a2;
    run_walk(32'h0030_0ABC, 1'b0, 1'b0, 1'b1, 32'h8000_0C02, 32'h0, 2, lat, flt, pa, freg, a1, a2);
    tests++;
    if (lat !== 6) begin fails++; $display("FAIL wait_lat got %0d want 6", lat); end
    tests++;
    if (pa !== 32'h8000_0ABC) begin fails++; $display("FAIL wait_pa got %h want 80000abc", pa); end
  endtask

  task automatic test_domain();
    int lat; logic flt, freg; logic [31:0] pa; logic [29:0] a1, a2;
    dacr = 32'h0;
    run_walk(32'h0030_0ABC, 1'b1, 1'b0, 1'b1, 32'h0000_0042, 32'h0, 0, lat, flt, pa, freg, a1, a2);
    tests++;
    if ({lat, freg, pa} !== {32'd4, 1'b1, 32'h0}) begin
      fails++; $display("FAIL dom_resp got lat %0d freg %b pa %h want 4/1/0", lat, freg, pa);
    end
    tests++;
    if ({fault_type, fault_page, fault_domain} !== {2'b10, 1'b0, 4'd2}) begin
      fails++; $display("FAIL dom_status got %b/%b/%0d want 10/0/2", fault_type, fault_page, fault_domain);
    end
    dacr = 32'h30;
    run_walk(32'h0030_0ABC, 1'b0, 1'b1, 1'b1, 32'h0000_0042, 32'h0, 0, lat, flt, pa, freg, a1, a2);
    tests++;
    if ({freg, pa} !== {1'b0, 32'h0000_0ABC}) begin
      fails++; $display("FAIL mgr_pass got freg %b pa %h want 0/00000abc", freg, pa);
    end
  endtask

  task automatic test_l1_fault();
    int lat; logic flt, freg; logic [31:0] pa; logic [29:0] a1, a2;
    dacr = 32'h1;
    run_walk(32'h0030_0ABC, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0, 0, lat, flt, pa, freg, a1, a2);
    tests++;
    if ({lat, freg} !== {32'd3, 1'b1}) begin
      fails++; $display("FAIL l1f_resp got lat %0d freg %b want 3/1", lat, freg);
    end
    tests++;
    if ({fault_type, fault_page, fault_domain, fault_addr} !== {2'b01, 1'b0, 4'd0, 32'h0030_0ABC}) begin
      fails++; $display("FAIL l1f_status got %b/%b/%0d/%h want 01/0/0/00300abc",
                        fault_type, fault_page, fault_domain, fault_addr);
    end
  endtask

  task automatic test_page();
    int lat; logic flt, freg; logic [31:0] pa; logic [29:0] a1, a2;
    dacr = 32'h4;
    run_walk(32'h0035_6ABC, 1'b0, 1'b0, 1'b1, 32'h0010_0021, 32'h1234_5012, 0, lat, flt, pa, freg, a1, a2);
    tests++;
    if ({a1, a2} !== {30'h1003, 30'h40056}) begin
      fails++; $display("FAIL pg_addr got %h/%h want 1003/40056", a1, a2);
    end
    tests++;
    if ({lat, freg, pa} !== {32'd6, 1'b1, 32'h0}) begin
      fails++; $display("FAIL pg_perm got lat %0d freg %b pa %h want 6/1/0", lat, freg, pa);
    end
    tests++;
    if ({fault_type, fault_page, fault_domain, fault_addr} !== {2'b11, 1'b1, 4'd1, 32'h0035_6ABC}) begin
      fails++; $display("FAIL pg_status got %b/%b/%0d/%h want 11/1/1/00356abc",
                        fault_type, fault_page, fault_domain, fault_addr);
    end
    run_walk(32'h0035_6ABC, 1'b1, 1'b0, 1'b1, 32'h0010_0021, 32'h1234_5012, 0, lat, flt, pa, freg, a1, a2);
    tests++;
    if ({lat, freg, pa} !== {32'd6, 1'b0, 32'h1234_5ABC}) begin
      fails++; $display("FAIL pg_small got lat %0d freg %b pa %h want 6/0/12345abc", lat, freg, pa);
    end
    run_walk(32'h0035_6ABC, 1'b1, 1'b1, 1'b1, 32'h0010_0021, 32'hABCD_0011, 0, lat, flt, pa, freg, a1, a2);
    tests++;
    if ({freg, pa} !== {1'b0, 32'hABCD_6ABC}) begin
      fails++; $display("FAIL pg_large got freg %b pa %h want 0/abcd6abc", freg, pa);
    end
    run_walk(32'h0035_6ABC, 1'b0, 1'b1, 1'b1, 32'h0010_0021, 32'h1234_5022, 0, lat, flt, pa, freg, a1, a2);
    tests++;
    if ({freg, fault_type} !== {1'b1, 2'b11}) begin
      fails++; $display("FAIL ap10_write got freg %b type %b want 1/11", freg, fault_type);
    end
    run_walk(32'h0035_6ABC, 1'b0, 1'b0, 1'b1, 32'h0010_0021, 32'h1234_5022, 0, lat, flt, pa, freg, a1, a2);
    tests++;
    if ({freg, pa} !== {1'b0, 32'h1234_5ABC}) begin
      fails++; $display("FAIL ap10_read got freg %b pa %h want 0/12345abc", freg, pa);
    end
    run_walk(32'h0035_6ABC, 1'b1, 1'b0, 1'b1, 32'h0010_0021, 32'h0000_0003, 0, lat, flt, pa, freg, a1, a2);
    tests++;
    if ({lat, freg, fault_type, fault_page, fault_domain} !== {32'd5, 1'b1, 2'b01, 1'b1, 4'd1}) begin
      fails++; $display("FAIL l2f got lat %0d freg %b %b/%b/%0d want 5/1 01/1/1",
                        lat, freg, fault_type, fault_page, fault_domain);
    end
  endtask

  task automatic test_reset_midwalk();
    int lat; logic flt, freg; logic [31:0] pa; logic [29:0] a1, a2;
    logic seen;
    dacr = 32'h4;
    req_valid = 1'b1; req_va = 32'h0035_6ABC; req_priv = 1'b1; req_write = 1'b0; mmu_enable = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests++;
    if ({bus_start, req_ready} !== 2'b10) begin
      fails++; $display("FAIL mid_l1req got start %b ready %b want 1/0", bus_start, req_ready);
    end
    @(posedge clk); #1;
    bus_ready = 1'b1; bus_data_rd = 32'h0010_0021;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_ready = 1'b1; bus_data_rd = 32'h1234_5012;
    tests++;
    if ({bus_start, resp_valid, resp_fault, fault_register, fault_page, fault_type,
         fault_domain, resp_pa, fault_addr, bus_addr, req_ready} !== {110'd0, 1'b1}) begin
      fails++; $display("FAIL mid_reset got nonzero (faddr %h baddr %h ready %b) want 0", fault_addr, bus_addr, req_ready);
    end
    @(posedge clk); #1;
    bus_ready = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      if (resp_valid || bus_start) seen = 1'b1;
      @(posedge clk); #1;
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL mid_noresp got activity %b want 0", seen); end
    run_walk(32'h0035_6ABC, 1'b1, 1'b0, 1'b1, 32'h0010_0021, 32'h1234_5012, 0, lat, flt, pa, freg, a1, a2);
    tests++;
    if ({lat, freg, pa} !== {32'd6, 1'b0, 32'h1234_5ABC}) begin
      fails++; $display("FAIL mid_after got lat %0d freg %b pa %h want 6/0/12345abc", lat, freg, pa);
    end
  endtask

  initial begin
    rst = 1'b1; mmu_enable = 1'b0; ttbr = 32'h0000_4000; dacr = 32'h1;
    req_valid = 1'b0; req_va = '0; req_priv = 1'b0; req_write = 1'b0;
    bus_ready = 1'b0; bus_data_rd = '0;
    test_reset();
    test_mmu_off();
    test_section();
    test_bus_wait();
    test_domain();
    test_l1_fault();
    test_page();
    test_reset_midwalk();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
